// File: rtl/decode_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_scoreboard_if
// Description : Decode-stage issue/bypass/writeback bundle between the decode
//               stage (master) and the register scoreboard (slave).
//               master drives : issue_valid_i, issue_unit_i, issue_rd_i,
//                               issue_rs1_i, issue_rs2_i, use_rs1_i,
//                               use_rs2_i, flush_i
//               master reads  : stall_o, issue_fire_o, fwd_rs1_sel_o,
//                               fwd_rs2_sel_o, busy_o, wb_valid_o, wb_rd_o,
//                               wb_unit_o
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_scoreboard_if #(
  parameter int NREG  = 32,
  parameter int IDX_W = $clog2(NREG),
  parameter int NUNIT = 3
);
  localparam int UW = (NUNIT > 1) ? $clog2(NUNIT) : 1;
  localparam int SW = $clog2(NUNIT + 1);

  logic             issue_valid_i;
  logic [UW-1:0]    issue_unit_i;
  logic [IDX_W-1:0] issue_rd_i;
  logic [IDX_W-1:0] issue_rs1_i;
  logic [IDX_W-1:0] issue_rs2_i;
  logic             use_rs1_i;
  logic             use_rs2_i;
  logic             flush_i;
  logic             stall_o;
  logic             issue_fire_o;
  logic [SW-1:0]    fwd_rs1_sel_o;
  logic [SW-1:0]    fwd_rs2_sel_o;
  logic [NREG-1:0]  busy_o;
  logic             wb_valid_o;
  logic [IDX_W-1:0] wb_rd_o;
  logic [UW-1:0]    wb_unit_o;

  modport master (
    output issue_valid_i, issue_unit_i, issue_rd_i, issue_rs1_i, issue_rs2_i,
           use_rs1_i, use_rs2_i, flush_i,
    input  stall_o, issue_fire_o, fwd_rs1_sel_o, fwd_rs2_sel_o, busy_o,
           wb_valid_o, wb_rd_o, wb_unit_o
  );

  modport slave (
    input  issue_valid_i, issue_unit_i, issue_rd_i, issue_rs1_i, issue_rs2_i,
           use_rs1_i, use_rs2_i, flush_i,
    output stall_o, issue_fire_o, fwd_rs1_sel_o, fwd_rs2_sel_o, busy_o,
           wb_valid_o, wb_rd_o, wb_unit_o
  );
endinterface
`default_nettype wire

// File: rtl/decode_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : decode_scoreboard
// Description : Register scoreboard for the decode stage. Tracks in-flight
//               destinations of NUNIT fixed-latency units, resolves RAW / WAW /
//               writeback-port hazards and produces per-source bypass selects.
// Ports       : clk    - rising-edge clock
//               reset  - asynchronous active-high clear of all state
//               sb     - decode_scoreboard_if.slave (issue request, stall/fire,
//                        bypass selects, busy vector, writeback report)
// Revision    : 1.0 - initial release
// ============================================================================
module decode_scoreboard #(
  parameter int                     NREG     = 32,
  parameter int                     IDX_W    = $clog2(NREG),
  parameter int                     NUNIT    = 3,
  parameter int                     LAT_W    = 4,
  parameter logic [NUNIT*LAT_W-1:0] UNIT_LAT = {4'd5, 4'd2, 4'd1},
  parameter int                     MAXL     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  decode_scoreboard_if.slave   sb
);
  localparam int UW = (NUNIT > 1) ? $clog2(NUNIT) : 1;
  localparam int SW = $clog2(NUNIT + 1);

  // Per-register countdown (0 = idle) and producing unit.
  logic [LAT_W-1:0] r_cnt  [NREG];
  logic [UW-1:0]    r_tag  [NREG];
  // Writeback pipeline: slot k retires at the end of the cycle k-1 from now.
  logic             r_slot_v    [1:MAXL];
  logic [IDX_W-1:0] r_slot_rd   [1:MAXL];
  logic [UW-1:0]    r_slot_unit [1:MAXL];

  logic [LAT_W-1:0] w_lat;
  logic             w_rd_nz;
  logic             w_raw1, w_raw2, w_waw, w_struct, w_req, w_stall, w_fire;
  logic [SW-1:0]    w_sel1, w_sel2;

  // Latency of the unit the decode instruction targets.
  always_comb begin
    w_lat = UNIT_LAT[LAT_W-1:0];
    for (int u = 0; u < NUNIT; u++) begin
      if (sb.issue_unit_i == UW'(u)) w_lat = UNIT_LAT[u*LAT_W +: LAT_W];
    end
  end

  // Source checks: a countdown of exactly 1 means the producer writes back at
  // the end of this cycle, so its result is on the bypass network now.
  always_comb begin
    w_raw1 = 1'b0;
    w_sel1 = '0;
    if (sb.use_rs1_i && (sb.issue_rs1_i != '0)) begin
      if (r_cnt[sb.issue_rs1_i] >= LAT_W'(2))      w_raw1 = 1'b1;
      else if (r_cnt[sb.issue_rs1_i] == LAT_W'(1)) w_sel1 = SW'(r_tag[sb.issue_rs1_i]) + SW'(1);
    end
    w_raw2 = 1'b0;
    w_sel2 = '0;
    if (sb.use_rs2_i && (sb.issue_rs2_i != '0)) begin
      if (r_cnt[sb.issue_rs2_i] >= LAT_W'(2))      w_raw2 = 1'b1;
      else if (r_cnt[sb.issue_rs2_i] == LAT_W'(1)) w_sel2 = SW'(r_tag[sb.issue_rs2_i]) + SW'(1);
    end
  end

  // Writeback-port conflict: slots shift on the issue edge, so the new entry
  // would collide with whatever currently sits one slot above its landing slot.
  // A unit of maximum latency lands in the top slot, which nothing can occupy.
  always_comb begin
    w_struct = 1'b0;
    for (int k = 2; k <= MAXL; k++) begin
      if ((w_lat == LAT_W'(k - 1)) && r_slot_v[k]) w_struct = 1'b1;
    end
  end

  assign w_rd_nz = (sb.issue_rd_i != '0);
  // An older producer must not retire after a younger one to the same register.
  assign w_waw   = w_rd_nz && (r_cnt[sb.issue_rd_i] > w_lat);
  assign w_req   = sb.issue_valid_i && !sb.flush_i;
  assign w_stall = w_req && (w_raw1 || w_raw2 || w_waw || (w_rd_nz && w_struct));
  assign w_fire  = w_req && !w_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= '0;
        r_tag[r] <= '0;
      end
      for (int k = 1; k <= MAXL; k++) begin
        r_slot_v[k]    <= 1'b0;
        r_slot_rd[k]   <= '0;
        r_slot_unit[k] <= '0;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (r_cnt[r] != '0) r_cnt[r] <= r_cnt[r] - LAT_W'(1);
      end
      for (int k = 1; k < MAXL; k++) begin
        r_slot_v[k]    <= r_slot_v[k+1];
        r_slot_rd[k]   <= r_slot_rd[k+1];
        r_slot_unit[k] <= r_slot_unit[k+1];
      end
      r_slot_v[MAXL]    <= 1'b0;
      r_slot_rd[MAXL]   <= '0;
      r_slot_unit[MAXL] <= '0;
      // The youngest producer takes ownership, overriding any older countdown.
      if (w_fire && w_rd_nz) begin
        r_cnt[sb.issue_rd_i] <= w_lat;
        r_tag[sb.issue_rd_i] <= sb.issue_unit_i;
        for (int k = 1; k <= MAXL; k++) begin
          if (w_lat == LAT_W'(k)) begin
            r_slot_v[k]    <= 1'b1;
            r_slot_rd[k]   <= sb.issue_rd_i;
            r_slot_unit[k] <= sb.issue_unit_i;
          end
        end
      end
    end
  end

  always_comb begin
    sb.busy_o = '0;
    for (int r = 1; r < NREG; r++) sb.busy_o[r] = (r_cnt[r] != '0);
  end

  assign sb.stall_o       = w_stall;
  assign sb.issue_fire_o  = w_fire;
  assign sb.fwd_rs1_sel_o = w_sel1;
  assign sb.fwd_rs2_sel_o = w_sel2;
  assign sb.wb_valid_o    = r_slot_v[1];
  assign sb.wb_rd_o       = r_slot_rd[1];
  assign sb.wb_unit_o     = r_slot_unit[1];

endmodule
`default_nettype wire

// File: tb/tb_decode_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_scoreboard
// Description : Self-checking bench for decode_scoreboard. The reference model
//               tracks, per register, the absolute cycle in which its pending
//               writeback completes, plus a map of cycle -> scheduled writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_scoreboard;
  localparam int NREG = 32, IDX_W = 5, NUNIT = 3, LAT_W = 4, MAXL = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_scoreboard_if #(.NREG(NREG), .IDX_W(IDX_W), .NUNIT(NUNIT)) sb_if ();

  decode_scoreboard #(
    .NREG(NREG), .IDX_W(IDX_W), .NUNIT(NUNIT), .LAT_W(LAT_W),
    .UNIT_LAT({4'd5, 4'd2, 4'd1}), .MAXL(MAXL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sb(sb_if)
  );

  // Reference model state.
  int lat_m [NUNIT] = '{1, 2, 5};
  int pend  [NREG];            // cycle of final writeback, -1 when idle
  int tagm  [NREG];
  int wb_rd_at [int];
  int wb_un_at [int];
  int mc;

  int checks   = 0;
  int failures = 0;

  // Observations of the most recent cycle.
  logic        o_stall, o_fire, o_wbv;
  logic [1:0]  o_sel1, o_sel2, o_wbu;
  logic [4:0]  o_wbrd;
  logic [31:0] o_busy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) begin
      pend[r] = -1;
      tagm[r] = 0;
    end
    wb_rd_at.delete();
    wb_un_at.delete();
  endtask

  // One decode cycle: drive, check against the model mid-cycle, advance.
  task automatic cyc(input bit v, input int unit, input int rd, input int rs1,
                     input int rs2, input bit u1, input bit u2, input bit fl);
    int L, e_sel1, e_sel2;
    bit raw1, raw2, waw, strc, e_stall, e_fire;
    logic [31:0] e_busy;
    sb_if.issue_valid_i = v;
    sb_if.issue_unit_i  = 2'(unit);
    sb_if.issue_rd_i    = 5'(rd);
    sb_if.issue_rs1_i   = 5'(rs1);
    sb_if.issue_rs2_i   = 5'(rs2);
    sb_if.use_rs1_i     = u1;
    sb_if.use_rs2_i     = u2;
    sb_if.flush_i       = fl;
    @(negedge clk);
    L      = lat_m[unit];
    raw1   = u1 && rs1 != 0 && pend[rs1] > mc;
    raw2   = u2 && rs2 != 0 && pend[rs2] > mc;
    e_sel1 = (u1 && rs1 != 0 && pend[rs1] == mc) ? tagm[rs1] + 1 : 0;
    e_sel2 = (u2 && rs2 != 0 && pend[rs2] == mc) ? tagm[rs2] + 1 : 0;
    waw    = rd != 0 && (pend[rd] - mc + 1) > L;
    strc   = rd != 0 && wb_rd_at.exists(mc + L);
    e_stall = v && !fl && (raw1 || raw2 || waw || strc);
    e_fire  = v && !fl && !e_stall;
    for (int r = 0; r < NREG; r++) e_busy[r] = (r != 0) && (pend[r] >= mc);

    o_stall = sb_if.stall_o;       o_fire = sb_if.issue_fire_o;
    o_sel1  = sb_if.fwd_rs1_sel_o; o_sel2 = sb_if.fwd_rs2_sel_o;
    o_busy  = sb_if.busy_o;        o_wbv  = sb_if.wb_valid_o;
    o_wbrd  = sb_if.wb_rd_o;       o_wbu  = sb_if.wb_unit_o;

    chk("stall", o_stall, e_stall);
    chk("fire",  o_fire,  e_fire);
    chk("sel1",  o_sel1,  e_sel1);
    chk("sel2",  o_sel2,  e_sel2);
    chk("busy",  o_busy,  e_busy);
    chk("wb_valid", o_wbv, wb_rd_at.exists(mc));
    if (wb_rd_at.exists(mc)) begin
      chk("wb_rd",   o_wbrd, wb_rd_at[mc]);
      chk("wb_unit", o_wbu,  wb_un_at[mc]);
      wb_rd_at.delete(mc);
      wb_un_at.delete(mc);
    end
    if (e_fire && rd != 0) begin
      pend[rd] = mc + L;
      tagm[rd] = unit;
      wb_rd_at[mc + L] = rd;
      wb_un_at[mc + L] = unit;
    end
    mc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset pulse taken in the middle of a cycle.
  task automatic do_reset();
    sb_if.issue_valid_i = 1'b0;
    sb_if.flush_i       = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_busy",     sb_if.busy_o,        32'd0);
    chk("rst_wb_valid", sb_if.wb_valid_o,    1'b0);
    chk("rst_stall",    sb_if.stall_o,       1'b0);
    chk("rst_sel1",     sb_if.fwd_rs1_sel_o, 2'd0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bit fired;
    int fire_at;
    model_clear();
    mc = 0;
    reset = 1'b1;
    sb_if.issue_valid_i = 0; sb_if.issue_unit_i = 0; sb_if.issue_rd_i = 0;
    sb_if.issue_rs1_i = 0;   sb_if.issue_rs2_i = 0;  sb_if.use_rs1_i = 0;
    sb_if.use_rs2_i = 0;     sb_if.flush_i = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy",  sb_if.busy_o,     32'd0);
    chk("reset_wbv",   sb_if.wb_valid_o, 1'b0);
    chk("reset_stall", sb_if.stall_o,    1'b0);
    reset = 1'b0;

    // ALU producer, consumer forwards next cycle, register file after.
    cyc(1, 0, 5, 0, 0, 0, 0, 0);
    chk("alu_fire", o_fire, 1'b1);
    cyc(1, 0, 0, 5, 0, 1, 0, 0);
    chk("alu_stall", o_stall, 1'b0);
    chk("alu_sel1",  o_sel1, 2'd1);
    chk("alu_wbrd",  o_wbrd, 5'd5);
    cyc(1, 0, 0, 5, 0, 1, 0, 0);
    chk("alu_sel1_rf", o_sel1, 2'd0);
    chk("alu_busy5",   o_busy[5], 1'b0);
    idle(6);

    // Load producer: one stall then bypass from unit 1.
    cyc(1, 1, 6, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 6, 0, 1, 0);
    chk("ld_stall", o_stall, 1'b1);
    cyc(1, 0, 0, 0, 6, 0, 1, 0);
    chk("ld_fire", o_fire, 1'b1);
    chk("ld_sel2", o_sel2, 2'd2);
    idle(6);

    // Writeback-port conflict between MUL and a later ALU op.
    cyc(1, 2, 7, 0, 0, 0, 0, 0);
    idle(3);
    cyc(1, 0, 8, 0, 0, 0, 0, 0);
    chk("st_stall", o_stall, 1'b1);
    cyc(1, 0, 8, 0, 0, 0, 0, 0);
    chk("st_fire", o_fire, 1'b1);
    chk("st_wb7",  o_wbrd, 5'd7);
    idle(1);
    chk("st_wb8",  o_wbrd, 5'd8);
    idle(6);

    // WAW: ALU rewriting a MUL destination waits until order is safe.
    cyc(1, 2, 9, 0, 0, 0, 0, 0);
    fired = 0;
    fire_at = 0;
    for (int i = 1; i <= 8 && !fired; i++) begin
      cyc(1, 0, 9, 0, 0, 0, 0, 0);
      if (o_fire) begin
        fired = 1;
        fire_at = i;
      end
    end
    chk("waw_fired",  fired, 1'b1);
    chk("waw_cycle",  fire_at, 5);
    chk("waw_wb5",    o_wbrd, 5'd9);
    idle(1);
    chk("waw_wb6",    o_wbrd, 5'd9);
    idle(1);
    chk("waw_busy9",  o_busy[9], 1'b0);
    idle(6);

    // rd=x0 with unused busy source, then the same instruction flushed.
    cyc(1, 2, 7, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 7, 0, 0, 0, 0);
    chk("x0_stall", o_stall, 1'b0);
    chk("x0_fire",  o_fire, 1'b1);
    chk("x0_busy0", o_busy[0], 1'b0);
    cyc(1, 0, 0, 7, 0, 0, 0, 1);
    chk("flush_fire", o_fire, 1'b0);
    idle(3);
    chk("flush_wb7_v",  o_wbv, 1'b1);
    chk("flush_wb7_rd", o_wbrd, 5'd7);
    idle(6);

    // Mixed in-flight work discarded by a reset pulse.
    cyc(1, 0, 13, 0, 0, 0, 0, 0);
    cyc(1, 1, 12, 0, 0, 0, 0, 0);
    cyc(1, 2, 11, 0, 0, 0, 0, 0);
    chk("pre_rst_busy11", sb_if.busy_o[11], 1'b1);
    do_reset();
    cyc(1, 1, 14, 13, 12, 1, 1, 0);
    chk("post_rst_fire", o_fire, 1'b1);
    chk("post_rst_sel1", o_sel1, 2'd0);
    chk("post_rst_sel2", o_sel2, 2'd0);
    idle(6);

    // Randomized traffic on a small register window to provoke hazards.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 9) < 8, $urandom_range(0, 2), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/decode_scoreboard.md
# decode_scoreboard

Parametrised register scoreboard for the decode stage. It tracks every in-flight destination register across N functional units with independent fixed latencies. Each cycle it decides whether the instruction in decode may issue, given RAW, WAW and single-writeback-port structural hazards. For each source operand it produces a bypass select, replacing the fixed EX/MEM/M0–M4 rd-compare logic in decode with one generic mechanism.

## Interface
Parameters:
- NREG, 32, architectural register count; x0 is never tracked.
- IDX_W, $clog2(NREG), register index width.
- NUNIT, 3, number of functional units; unit ids are 0..NUNIT-1.
- LAT_W, 4, latency field width.
- UNIT_LAT, {4'd5,4'd2,4'd1}, packed NUNIT×LAT_W latencies; unit u uses UNIT_LAT[u*LAT_W +: LAT_W]. Each latency is in 1..2^LAT_W-2.
- MAXL, 5, maximum entry of UNIT_LAT; sets the writeback shift depth.

Ports (UW=$clog2(NUNIT), SW=$clog2(NUNIT+1)):
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- issue_valid_i  in  1  decode holds a valid instruction.
- issue_unit_i  in  UW  target unit of that instruction.
- issue_rd_i  in  IDX_W  destination register; 0 means no write.
- issue_rs1_i, issue_rs2_i  in  IDX_W  source registers.
- use_rs1_i, use_rs2_i  in  1  source is actually read.
- flush_i  in  1  squash the decode instruction this cycle.
- stall_o  out  1  decode must hold and fetch must stall.
- issue_fire_o  out  1  instruction accepted this cycle.
- fwd_rs1_sel_o, fwd_rs2_sel_o  out  SW  0 = register file; u+1 = bypass from unit u.
- busy_o  out  NREG  per-register pending bits.
- wb_valid_o  out  1  a tracked writeback completes at the end of this cycle.
- wb_rd_o  out  IDX_W  register written at the end of this cycle.
- wb_unit_o  out  UW  unit performing that writeback.

## Operation
- Per-register state: cnt[r] (LAT_W bits; 0 = idle) and tag[r] (UW bits). busy_o[r] = (cnt[r]!=0). Register 0 is hard-wired idle.
- Writeback shift register: slot[1..MAXL], each holding {v, rd, unit}.
  - Each cycle slot[k] <= slot[k+1], and slot[MAXL] <= 0.
  - On fire, slot[L] <= {1, rd, unit}, where L = latency of the issuing unit.
  - Outputs: wb_valid_o=slot[1].v, wb_rd_o=slot[1].rd, wb_unit_o=slot[1].unit.
- Countdown: every nonzero cnt decrements by 1 each cycle. A register whose cnt is 1 becomes idle next cycle unless it is re-issued in that same cycle.
- Source check, per source s with use_s=1 and s!=0:
  - cnt[s]>=2 → RAW stall.
  - cnt[s]==1 → sel = tag[s]+1.
  - Otherwise sel = 0.
  - When use_s=0 or s==0, sel = 0 and the source causes no stall.
- WAW: stall if rd!=0 and cnt[rd] > L. This guarantees writebacks happen in program order.
- Structural: stall if rd!=0 and slot[L+1].v is set, i.e. another writeback would land in the same cycle.
  - The check is against slot L+1 because slots shift at the issue edge.
  - When L == MAXL, slot[L+1] is treated as 0.
- stall_o = issue_valid_i & !flush_i & (RAW | WAW | structural).
- issue_fire_o = issue_valid_i & !flush_i & !stall_o.
- On fire with rd!=0: cnt[rd] <= L and tag[rd] <= unit. This overrides the decrement of any older entry for rd, so the youngest producer owns the register.
- On fire with rd==0: no state is updated.
- Flush suppresses fire and stall only. In-flight entries keep counting down and still write back.
- The block assumes back-end units never stall; latencies are exact.

## Timing
- Reset: all cnt/tag/slot cleared. All outputs read 0 combinationally from the cleared state: stall_o=0, fwd sels 0, busy_o=0, wb_valid_o=0.
- Reset asserted mid-operation discards every pending entry immediately. The first edge after deassertion sees an empty scoreboard.
- stall_o, issue_fire_o and fwd sels are combinational from inputs and current state; there is no added latency.
- State updates on the rising clk edge.
- Producer issued in cycle t (latency L):
  - busy from cycle t+1 through t+L.
  - Forwardable (sel=unit+1) in cycle t+L.
  - Written at the end of cycle t+L, where wb_valid_o=1.
  - Consumers from t+L+1 read the register file (sel=0).
- The RAW check uses the pre-update cnt. A consumer issued in the cycle after its producer sees that producer's cnt=L.

## Test plan
- ALU (unit 0, L=1) fires rd=x5 at cycle 0. Consumer rs1=x5 at cycle 1 → stall_o=0, fwd_rs1_sel_o=1, wb_valid_o=1 with wb_rd_o=5. Same consumer at cycle 2 → sel=0, busy_o[5]=0.
- LD (unit 1, L=2) fires rd=x6 at cycle 0. Consumer rs2=x6 at cycle 1 → stall_o=1. At cycle 2 → fire, fwd_rs2_sel_o=2.
- MUL (unit 2, L=5) fires rd=x7 at cycle 0. ALU rd=x8 with no source dependency offered at cycle 4 → stall_o=1 (structural). Fires at cycle 5. wb_rd_o=7 at cycle 5, then 8 at cycle 6.
- MUL fires rd=x9 at cycle 0. ALU rd=x9 offered continuously from cycle 1 → stalls cycles 1–4, fires at cycle 5. wb_rd_o=9 in cycles 5 and 6; busy_o[9]=0 at cycle 7.
- Instruction with rd=x0 and use_rs1_i=0, rs1=x7 while x7 is busy → no stall, busy_o[0]=0, no slot allocated. The same instruction with flush_i=1 → issue_fire_o=0, and the pending x7 still writes back on schedule.
- Three mixed instructions in flight, then reset pulsed for one cycle mid-operation → busy_o=0 and wb_valid_o=0 immediately. The next instruction fires with no stall and sel=0.
